// File: rtl/aes_pkg.sv
// aes_pkg: shared GF(2^8) helpers, MixColumns coefficient sets and the
// FSM state type used by mix_columns_iter and mix_single_column.
// No ports (package).
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // First row of each circulant matrix, leftmost coefficient in the MSB
    // byte. Row r is this row rotated right by r bytes.
    localparam logic [31:0] FWD_COEFS = 32'h02_03_01_01;
    localparam logic [31:0] INV_COEFS = 32'h0e_0b_0d_09;

    // Multiply by x (0x02) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiplier for the coefficients that occur in the two
    // matrices. Callers always pass a constant c, so only one arm survives.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] res;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'h01:   res = a;
            8'h02:   res = x2;
            8'h03:   res = x2 ^ a;
            8'h09:   res = x8 ^ a;
            8'h0b:   res = x8 ^ x2 ^ a;
            8'h0d:   res = x8 ^ x4 ^ a;
            8'h0e:   res = x8 ^ x4 ^ x2;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    // One output byte: dot product of four column bytes with a coefficient row.
    function automatic logic [7:0] mix_row(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3,
                                           input logic [31:0] c);
        return gf_mul(a0, c[31:24]) ^ gf_mul(a1, c[23:16]) ^
               gf_mul(a2, c[15:8])  ^ gf_mul(a3, c[7:0]);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// mix_single_column: combinational (Inv)MixColumns of one 32-bit column.
// Ports:
//   i_col     [31:0] column in, byte s(0,c) in [31:24]
//   i_inverse        1 = InvMixColumns (only honoured when SUPPORT_INV=1)
//   o_col     [31:0] transformed column, same byte order
module mix_single_column
    import aes_pkg::*;
#(
    parameter int SUPPORT_INV = 1
) (
    input  logic [31:0] i_col,
    input  logic        i_inverse,
    output logic [31:0] o_col
);

    logic [7:0]  w_a0;
    logic [7:0]  w_a1;
    logic [7:0]  w_a2;
    logic [7:0]  w_a3;
    logic [31:0] w_fwd;

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    // Rotating the bytes left by r is the same as rotating the
    // coefficient row right by r, so one row function covers all rows.
    assign w_fwd = {mix_row(w_a0, w_a1, w_a2, w_a3, FWD_COEFS),
                    mix_row(w_a1, w_a2, w_a3, w_a0, FWD_COEFS),
                    mix_row(w_a2, w_a3, w_a0, w_a1, FWD_COEFS),
                    mix_row(w_a3, w_a0, w_a1, w_a2, FWD_COEFS)};

    if (SUPPORT_INV != 0) begin : g_inv
        logic [31:0] w_inv;
        assign w_inv = {mix_row(w_a0, w_a1, w_a2, w_a3, INV_COEFS),
                        mix_row(w_a1, w_a2, w_a3, w_a0, INV_COEFS),
                        mix_row(w_a2, w_a3, w_a0, w_a1, INV_COEFS),
                        mix_row(w_a3, w_a0, w_a1, w_a2, INV_COEFS)};
        assign o_col = i_inverse ? w_inv : w_fwd;
    end else begin : g_fwd_only
        assign o_col = w_fwd;
    end

endmodule

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES (Inv)MixColumns over a 128-bit state,
// COLS_PER_CYCLE columns per compute cycle (1, 2 or 4).
// Ports:
//   clk, reset (async, active low)
//   in_valid / in_ready / in_data[127:0] / in_inverse : input handshake
//   out_valid / out_ready / out_data[127:0]           : output handshake
//   busy       high while in RUN or DONE
//   dbg_state  current FSM state (aes_pkg::state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_valid/in_data/in_inverse must be held until accepted;
// out_valid/out_data stay stable until out_ready is seen. in_ready is
// combinational (IDLE, or DONE with out_ready) and forced low in reset.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 4,
    parameter int SUPPORT_INV    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int N_GROUPS = 4 / COLS_PER_CYCLE;

    state_t             r_state;
    state_t             w_next;
    logic [0:3][31:0]   r_work;      // r_work[c] is column c
    logic [0:3][31:0]   w_work_next;
    logic               r_inv;
    logic               w_load;
    logic               w_last;
    logic [1:0]         w_grp;       // column group being transformed
    logic [31:0]        w_col_out [COLS_PER_CYCLE];

    // Group counter only exists when a block takes more than one cycle.
    // It wraps to 0 on the last group, which is the RUN->DONE transition.
    if (N_GROUPS > 1) begin : g_cnt
        localparam int CNT_W = $clog2(N_GROUPS);
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt <= '0;
            end else if (w_load) begin
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_grp  = 2'(r_cnt);
        assign w_last = (r_cnt == CNT_W'(N_GROUPS - 1));
    end else begin : g_no_cnt
        assign w_grp  = 2'b00;
        assign w_last = 1'b1;
    end

    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
        logic [1:0] w_idx;
        assign w_idx = 2'(int'(w_grp) * COLS_PER_CYCLE + gi);

        mix_single_column #(
            .SUPPORT_INV(SUPPORT_INV)
        ) u_mix (
            .i_col    (r_work[w_idx]),
            .i_inverse(r_inv),
            .o_col    (w_col_out[gi])
        );
    end

    // Column c belongs to group c/C and is served by engine c%C.
    for (genvar c = 0; c < 4; c++) begin : g_wb
        assign w_work_next[c] = (w_grp == 2'(c / COLS_PER_CYCLE))
                                ? w_col_out[c % COLS_PER_CYCLE] : r_work[c];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_work <= in_data;
                r_inv  <= (SUPPORT_INV != 0) && in_inverse;
            end else if (r_state == ST_RUN) begin
                r_work <= w_work_next;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_load = 1'b1;
                        w_next = ST_RUN;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // State is already IDLE during reset; keep upstream from seeing ready.
        in_ready = in_ready & reset;
    end

    assign out_data  = r_work;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: directed bench for mix_columns_iter. Four instances:
// C=4, C=2, C=1 (all with inverse support) and C=4 forward-only.
module tb_mix_columns_iter;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] W_IN     = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] W_OUT    = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] ONES     = {4{32'h01010101}};

    localparam int U4 = 0;
    localparam int U2 = 1;
    localparam int U1 = 2;
    localparam int UF = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n      [4];
    logic         in_valid   [4];
    logic         in_inverse [4];
    logic         out_ready  [4];
    logic [127:0] in_data    [4];
    logic         in_ready   [4];
    logic         out_valid  [4];
    logic [127:0] out_data   [4];
    logic         busy       [4];
    logic [1:0]   dbg_state  [4];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    mix_columns_iter #(.COLS_PER_CYCLE(4), .SUPPORT_INV(1)) u_c4 (
        .clk(clk), .reset(rst_n[U4]), .in_valid(in_valid[U4]), .in_ready(in_ready[U4]),
        .in_data(in_data[U4]), .in_inverse(in_inverse[U4]), .out_valid(out_valid[U4]),
        .out_ready(out_ready[U4]), .out_data(out_data[U4]), .busy(busy[U4]),
        .dbg_state(dbg_state[U4]));

    mix_columns_iter #(.COLS_PER_CYCLE(2), .SUPPORT_INV(1)) u_c2 (
        .clk(clk), .reset(rst_n[U2]), .in_valid(in_valid[U2]), .in_ready(in_ready[U2]),
        .in_data(in_data[U2]), .in_inverse(in_inverse[U2]), .out_valid(out_valid[U2]),
        .out_ready(out_ready[U2]), .out_data(out_data[U2]), .busy(busy[U2]),
        .dbg_state(dbg_state[U2]));

    mix_columns_iter #(.COLS_PER_CYCLE(1), .SUPPORT_INV(1)) u_c1 (
        .clk(clk), .reset(rst_n[U1]), .in_valid(in_valid[U1]), .in_ready(in_ready[U1]),
        .in_data(in_data[U1]), .in_inverse(in_inverse[U1]), .out_valid(out_valid[U1]),
        .out_ready(out_ready[U1]), .out_data(out_data[U1]), .busy(busy[U1]),
        .dbg_state(dbg_state[U1]));

    mix_columns_iter #(.COLS_PER_CYCLE(4), .SUPPORT_INV(0)) u_fwd (
        .clk(clk), .reset(rst_n[UF]), .in_valid(in_valid[UF]), .in_ready(in_ready[UF]),
        .in_data(in_data[UF]), .in_inverse(in_inverse[UF]), .out_valid(out_valid[UF]),
        .out_ready(out_ready[UF]), .out_data(out_data[UF]), .busy(busy[UF]),
        .dbg_state(dbg_state[UF]));

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after the accept edge; counts edges until out_valid is seen.
    task automatic wait_out(input int u, output int cycles);
        cycles = 0;
        while (out_valid[u] !== 1'b1 && cycles < 12) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_block(input string tag, input int u, input logic [127:0] data,
                             input logic inv, input logic [127:0] exp, input int lat);
        int cyc;
        @(negedge clk);
        in_data[u]    = data;
        in_inverse[u] = inv;
        in_valid[u]   = 1'b1;
        out_ready[u]  = 1'b1;
        check({tag, "_in_ready"}, 128'(in_ready[u]), 128'(1));
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        wait_out(u, cyc);
        check({tag, "_latency"}, 128'(cyc), 128'(lat));
        check({tag, "_data"}, out_data[u], exp);
        @(posedge clk);
        #1;
        check({tag, "_back_to_idle"}, 128'(dbg_state[u]), 128'(S_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        for (int i = 0; i < 4; i++) begin
            rst_n[i]      = 1'b0;
            in_valid[i]   = 1'b0;
            in_inverse[i] = 1'b0;
            out_ready[i]  = 1'b0;
            in_data[i]    = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_in_ready_%0d", i), 128'(in_ready[i]), 128'(0));
            check($sformatf("rst_out_valid_%0d", i), 128'(out_valid[i]), 128'(0));
            check($sformatf("rst_busy_%0d", i), 128'(busy[i]), 128'(0));
            check($sformatf("rst_out_data_%0d", i), out_data[i], 128'(0));
        end
        for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post_rst_in_ready_%0d", i), 128'(in_ready[i]), 128'(1));
        end

        // Forward FIPS vector at every width, plus a second vector
        run_block("fwd_c4", U4, FIPS_IN, 1'b0, FIPS_OUT, 1);
        run_block("fwd_c2", U2, FIPS_IN, 1'b0, FIPS_OUT, 2);
        run_block("fwd_c1", U1, FIPS_IN, 1'b0, FIPS_OUT, 4);
        run_block("fwd_c4_w", U4, W_IN, 1'b0, W_OUT, 1);

        // Inverse round trip
        run_block("inv_c4", U4, FIPS_OUT, 1'b1, FIPS_IN, 1);
        run_block("inv_c2_w", U2, W_OUT, 1'b1, W_IN, 2);
        run_block("inv_c1", U1, FIPS_OUT, 1'b1, FIPS_IN, 4);

        // Forward-only build ignores in_inverse
        run_block("fonly_fips", UF, FIPS_IN, 1'b1, FIPS_OUT, 1);
        run_block("fonly_w", UF, W_IN, 1'b1, W_OUT, 1);

        // Identity columns
        run_block("zero_c2", U2, 128'(0), 1'b0, 128'(0), 2);
        run_block("ones_fwd", U2, ONES, 1'b0, ONES, 2);
        run_block("ones_inv", U1, ONES, 1'b1, ONES, 4);

        // Backpressure on C=2: stall 5 cycles with the next block pending
        @(negedge clk);
        in_data[U2]    = W_IN;
        in_inverse[U2] = 1'b0;
        in_valid[U2]   = 1'b1;
        out_ready[U2]  = 1'b0;
        @(posedge clk);
        #1;
        in_data[U2] = FIPS_IN;
        wait_out(U2, cyc);
        check("bp_latency", 128'(cyc), 128'(2));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", k), 128'(out_valid[U2]), 128'(1));
            check($sformatf("bp_data_%0d", k), out_data[U2], W_OUT);
            check($sformatf("bp_in_ready_%0d", k), 128'(in_ready[U2]), 128'(0));
        end
        out_ready[U2] = 1'b1;
        #1;
        check("bp_release_in_ready", 128'(in_ready[U2]), 128'(1));
        @(posedge clk);
        #1;
        check("bp_second_accept_state", 128'(dbg_state[U2]), 128'(S_RUN));
        check("bp_second_out_valid", 128'(out_valid[U2]), 128'(0));
        in_valid[U2] = 1'b0;
        wait_out(U2, cyc);
        check("bp_second_latency", 128'(cyc), 128'(2));
        check("bp_second_data", out_data[U2], FIPS_OUT);
        @(posedge clk);
        #1;
        check("bp_idle", 128'(dbg_state[U2]), 128'(S_IDLE));

        // Back-to-back on C=1: in_valid held, out_ready high
        @(negedge clk);
        in_data[U1]    = FIPS_IN;
        in_inverse[U1] = 1'b0;
        in_valid[U1]   = 1'b1;
        out_ready[U1]  = 1'b1;
        @(posedge clk);
        #1;
        in_data[U1] = W_IN;
        wait_out(U1, cyc);
        check("b2b_first_latency", 128'(cyc), 128'(4));
        check("b2b_first_data", out_data[U1], FIPS_OUT);
        check("b2b_done_in_ready", 128'(in_ready[U1]), 128'(1));
        @(posedge clk);
        #1;
        check("b2b_second_accept_state", 128'(dbg_state[U1]), 128'(S_RUN));
        in_valid[U1] = 1'b0;
        wait_out(U1, cyc);
        check("b2b_second_latency", 128'(cyc), 128'(4));
        check("b2b_second_data", out_data[U1], W_OUT);
        @(posedge clk);
        #1;
        check("b2b_idle", 128'(dbg_state[U1]), 128'(S_IDLE));

        // Reset during the second compute cycle of C=1
        @(negedge clk);
        in_data[U1]  = W_IN;
        in_valid[U1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[U1] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_run_state", 128'(dbg_state[U1]), 128'(S_RUN));
        rst_n[U1] = 1'b0;
        #1;
        check("mid_rst_in_ready", 128'(in_ready[U1]), 128'(0));
        check("mid_rst_out_valid", 128'(out_valid[U1]), 128'(0));
        check("mid_rst_busy", 128'(busy[U1]), 128'(0));
        check("mid_rst_out_data", out_data[U1], 128'(0));
        check("mid_rst_state", 128'(dbg_state[U1]), 128'(S_IDLE));
        repeat (2) @(negedge clk);
        check("mid_rst_hold_valid", 128'(out_valid[U1]), 128'(0));
        rst_n[U1] = 1'b1;
        @(negedge clk);
        check("post_mid_rst_in_ready", 128'(in_ready[U1]), 128'(1));
        repeat (5) @(negedge clk);
        check("post_mid_rst_no_stale", 128'(out_valid[U1]), 128'(0));
        run_block("after_rst_c1", U1, FIPS_IN, 1'b0, FIPS_OUT, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
